// File: rtl/persp_div_pkg.sv
// Shared constants for the perspective-divide stage and its divider.
// States are plain 2-bit localparams so they match the rest of the vertex path.
package persp_div_pkg;

    localparam logic [1:0] PD_IDLE  = 2'd0;
    localparam logic [1:0] PD_ISSUE = 2'd1;
    localparam logic [1:0] PD_WAIT  = 2'd2;
    localparam logic [1:0] PD_OUT   = 2'd3;

    localparam logic [1:0] LANE_X = 2'd0;
    localparam logic [1:0] LANE_Y = 2'd1;
    localparam logic [1:0] LANE_Z = 2'd2;

    localparam logic [1:0] DV_IDLE = 2'd0;
    localparam logic [1:0] DV_CALC = 2'd1;
    localparam logic [1:0] DV_FIN  = 2'd2;

endpackage

// File: rtl/persp_div_fxdiv.sv
// Signed fixed-point divider: val = a / b in Q(WIDTH-FBITS).FBITS,
// bit-serial restoring on magnitudes, round half to even, zero on error.
module persp_div_fxdiv
    import persp_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] val_o,
    output logic             dbz_o,
    output logic             ovf_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             valid_o
);
    localparam int NW = WIDTH - 1 + FBITS;
    localparam int CW = $clog2(NW);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [NW-1:0]    num_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-2:0] rem_q, ub_q;
    logic             neg_q;
    logic [WIDTH-1:0] val_q;
    logic             dbz_q, ovf_q, done_q;

    logic [WIDTH-1:0] r2, twice_rem, rnd;
    logic [WIDTH-2:0] diff, mag_a, mag_b;
    logic             ge, early_ovf, last, inc, start_err;

    always_comb begin
        r2        = {rem_q, num_q[NW-1]};
        ge        = r2 >= {1'b0, ub_q};
        diff      = (WIDTH-1)'(r2 - {1'b0, ub_q});
        // A quotient bit above the integer range means the result cannot fit.
        early_ovf = ge && (cnt_q < CW'(FBITS));
        last      = cnt_q == CW'(NW - 1);
        twice_rem = {rem_q, 1'b0};
        inc       = (twice_rem > {1'b0, ub_q}) ||
                    ((twice_rem == {1'b0, ub_q}) && quo_q[0]);
        rnd       = quo_q + WIDTH'(inc);
        mag_a     = a_i[WIDTH-1] ? (WIDTH-1)'(-a_i) : a_i[WIDTH-2:0];
        mag_b     = b_i[WIDTH-1] ? (WIDTH-1)'(-b_i) : b_i[WIDTH-2:0];
        start_err = (b_i == '0) || (a_i == MINV) || (b_i == MINV);
        state_d   = state_q;
        case (state_q)
            DV_IDLE: if (start_i && !start_err) state_d = DV_CALC;
            DV_CALC: begin
                if (early_ovf)  state_d = DV_IDLE;
                else if (last)  state_d = DV_FIN;
            end
            DV_FIN:  state_d = DV_IDLE;
            default: state_d = DV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DV_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ub_q    <= '0;
            neg_q   <= 1'b0;
            val_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                DV_IDLE: if (start_i) begin
                    neg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    num_q  <= {mag_a, {FBITS{1'b0}}};
                    ub_q   <= mag_b;
                    rem_q  <= '0;
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    val_q  <= '0;
                    dbz_q  <= b_i == '0;
                    ovf_q  <= (b_i != '0) && ((a_i == MINV) || (b_i == MINV));
                    done_q <= start_err;
                end
                DV_CALC: begin
                    rem_q <= ge ? diff : r2[WIDTH-2:0];
                    num_q <= num_q << 1;
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                    if (early_ovf) begin
                        ovf_q  <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                DV_FIN: begin
                    done_q <= 1'b1;
                    if (rnd[WIDTH-1]) ovf_q <= 1'b1;
                    else              val_q <= neg_q ? -rnd : rnd;
                end
                default: ;
            endcase
        end
    end

    assign val_o   = val_q;
    assign dbz_o   = dbz_q;
    assign ovf_o   = ovf_q;
    assign done_o  = done_q;
    assign busy_o  = state_q != DV_IDLE;
    assign valid_o = done_q && !dbz_q && !ovf_q;

endmodule

// File: rtl/persp_div.sv
// Perspective divide: (x,y,z,w) -> (x/w, y/w, z/w), three lanes
// issued in turn to one shared fixed-point divider.
module persp_div
    import persp_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [WIDTH-1:0] in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [2:0]       out_dbz,
    output logic [2:0]       out_ovf,
    output logic             busy
);
    logic [1:0]       state_q, state_d, lane_q, lane_d;
    logic [WIDTH-1:0] x_q, y_q, z_q, w_q;
    logic [WIDTH-1:0] res_x_q, res_y_q, res_z_q;
    logic [2:0]       dbz_q, ovf_q;
    logic             latch, wr, clr, div_start;
    logic [WIDTH-1:0] div_a, div_val;
    logic             div_dbz, div_ovf, div_done;
    logic             div_unused_busy, div_unused_valid;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        latch     = 1'b0;
        wr        = 1'b0;
        clr       = 1'b0;
        div_start = 1'b0;
        case (state_q)
            PD_IDLE: if (in_valid) begin
                latch   = 1'b1;
                lane_d  = LANE_X;
                state_d = PD_ISSUE;
            end
            PD_ISSUE: begin
                div_start = 1'b1;
                state_d   = PD_WAIT;
            end
            PD_WAIT: if (div_done) begin
                wr = 1'b1;
                if (lane_q == LANE_Z) begin
                    state_d = PD_OUT;
                end else begin
                    lane_d  = lane_q + 2'd1;
                    state_d = PD_ISSUE;
                end
            end
            PD_OUT: if (out_ready) begin
                clr     = 1'b1;
                state_d = PD_IDLE;
            end
            default: state_d = PD_IDLE;
        endcase
    end

    always_comb begin
        case (lane_q)
            LANE_Y:  div_a = y_q;
            LANE_Z:  div_a = z_q;
            default: div_a = x_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PD_IDLE;
            lane_q  <= LANE_X;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            w_q     <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            res_z_q <= '0;
            dbz_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (latch) begin
                x_q <= in_x;
                y_q <= in_y;
                z_q <= in_z;
                w_q <= in_w;
            end
            if (wr) begin
                if (lane_q == LANE_X) res_x_q <= div_val;
                if (lane_q == LANE_Y) res_y_q <= div_val;
                if (lane_q == LANE_Z) res_z_q <= div_val;
                dbz_q[lane_q] <= div_dbz;
                ovf_q[lane_q] <= div_ovf;
            end
            if (clr) begin
                dbz_q <= '0;
                ovf_q <= '0;
            end
        end
    end

    persp_div_fxdiv #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_div (
        .clk     (clk),
        .rst     (~rst_n),
        .start_i (div_start),
        .a_i     (div_a),
        .b_i     (w_q),
        .val_o   (div_val),
        .dbz_o   (div_dbz),
        .ovf_o   (div_ovf),
        .done_o  (div_done),
        .busy_o  (div_unused_busy),
        .valid_o (div_unused_valid)
    );

    assign in_ready  = state_q == PD_IDLE;
    assign busy      = state_q != PD_IDLE;
    assign out_valid = state_q == PD_OUT;
    assign out_x     = res_x_q;
    assign out_y     = res_y_q;
    assign out_z     = res_z_q;
    assign out_dbz   = dbz_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_persp_div.sv
// Randomized and directed bench for persp_div against an arithmetic
// reference of signed fixed-point division with round-half-even.
module tb_persp_div;

    localparam int WIDTH = 32;
    localparam int FBITS = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_x = '0, in_y = '0, in_z = '0, in_w = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_x, out_y, out_z;
    logic [2:0]       out_dbz, out_ovf;
    logic             busy;

    int n_checks = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    persp_div #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: q = n / w in Q16.16, round half to even, zero on error.
    task automatic model(input logic [31:0] n, input logic [31:0] w,
                         output logic [31:0] q, output logic dbz,
                         output logic ovf);
        longint sn, sw, an, aw, num, qq, rr;
        q = '0;
        dbz = 1'b0;
        ovf = 1'b0;
        if (w == 32'd0) begin
            dbz = 1'b1;
        end else if (n == 32'h8000_0000 || w == 32'h8000_0000) begin
            ovf = 1'b1;
        end else begin
            sn = longint'($signed(n));
            sw = longint'($signed(w));
            an = (sn < 0) ? -sn : sn;
            aw = (sw < 0) ? -sw : sw;
            num = an * 65536;
            qq = num / aw;
            rr = num % aw;
            if (2 * rr > aw || (2 * rr == aw && (qq % 2) == 1)) qq = qq + 1;
            if (qq >= 64'sd2147483648) ovf = 1'b1;
            else q = 32'(((sn < 0) != (sw < 0)) ? -qq : qq);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [31:0] w);
        int t;
        @(negedge clk);
        in_x = x;
        in_y = y;
        in_z = z;
        in_w = w;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] z,
                             input logic [31:0] w);
        logic [31:0] qx, qy, qz;
        logic        dx, dy, dz, ox, oy, oz;
        model(x, w, qx, dx, ox);
        model(y, w, qy, dy, oy);
        model(z, w, qz, dz, oz);
        check({tag, ".x"}, out_x, qx);
        check({tag, ".y"}, out_y, qy);
        check({tag, ".z"}, out_z, qz);
        check({tag, ".dbz"}, 32'(out_dbz), 32'({dz, dy, dx}));
        check({tag, ".ovf"}, 32'(out_ovf), 32'({oz, oy, ox}));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic vertex(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z,
                          input logic [31:0] w);
        int lat;
        send(x, y, z, w);
        wait_out(lat);
        check_out(tag, x, y, z, w);
        release_out();
    endtask

    function automatic logic [31:0] rand_val(input bit allow_zero);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 6))
            0: v = v;
            1: v = 32'($signed(v) >>> $urandom_range(4, 24));
            2: v = allow_zero ? 32'd0 : 32'h0001_0000;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 7));
            5: v = 32'($signed(v) >>> 12);
            default: v = 32'($signed(v) >>> $urandom_range(0, 30));
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        logic [31:0] rx, ry, rz, rw;

        #12;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.out_x", out_x, 32'd0);
        check("rst.flags", 32'({out_dbz, out_ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vertex("t1", 32'h0003_0000, 32'hFFFF_0000, 32'h0, 32'h0002_0000);

        send(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        wait_out(lat);
        check("t2.latency", 32'(lat), 32'd7);
        check_out("t2", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        release_out();

        vertex("t3", 32'h4000_0000, 32'h8000_0000, 32'h0001_0000,
               32'h0000_0100);
        vertex("t4", 32'h1, 32'h3, 32'h5, 32'h0002_0000);

        send(32'h0003_0000, 32'hFFFF_0000, 32'h0, 32'h0002_0000);
        wait_out(lat);
        @(negedge clk);
        in_x = 32'h0000_0005;
        in_y = 32'hFFFF_FFFB;
        in_z = 32'h0123_4567;
        in_w = 32'hFFFE_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out("t5.hold", 32'h0003_0000, 32'hFFFF_0000, 32'h0,
                      32'h0002_0000);
            check("t5.in_ready", 32'(in_ready), 32'd0);
            check("t5.out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("t5.idle_ready", 32'(in_ready), 32'd1);
        check("t5.idle_valid", 32'(out_valid), 32'd0);
        check("t5.flags_clr", 32'({out_dbz, out_ovf}), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("t5.accept_busy", 32'(busy), 32'd1);
        wait_out(lat);
        check_out("t5.next", 32'h0000_0005, 32'hFFFF_FFFB, 32'h0123_4567,
                  32'hFFFE_0000);
        release_out();

        send(32'h0003_0000, 32'hFFFF_0000, 32'h0, 32'h0002_0000);
        repeat (70) @(negedge clk);
        check("t6.mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6.rst_busy", 32'(busy), 32'd0);
        check("t6.rst_ready", 32'(in_ready), 32'd1);
        check("t6.rst_valid", 32'(out_valid), 32'd0);
        check("t6.rst_out_x", out_x, 32'd0);
        check("t6.rst_flags", 32'({out_dbz, out_ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vertex("t6.replay", 32'h0003_0000, 32'hFFFF_0000, 32'h0,
               32'h0002_0000);

        for (int i = 0; i < 40; i++) begin
            rx = rand_val(1'b1);
            ry = rand_val(1'b1);
            rz = rand_val(1'b1);
            rw = ($urandom_range(0, 9) == 0) ? 32'd0 : rand_val(1'b0);
            send(rx, ry, rz, rw);
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_out("rnd", rx, ry, rz, rw);
            release_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
